// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and the memory (slave).
interface if_stage_if #(
  parameter int PC_WIDTH   = 15,
  parameter int DATA_WIDTH = 16
);
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_ready;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, one-entry stall buffer and the IF/ID register.
// Define IF_PERF_CNT_EN to add the saturating perf_stall_cnt output.
module if_stage #(
  parameter int PC_WIDTH   = 15,
  parameter int DATA_WIDTH = 16,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  if_stage_if.master            imem,
  output logic                  id_valid,
  output logic [PC_WIDTH-1:0]   id_pc,
  output logic [DATA_WIDTH-1:0] id_instr
`ifdef IF_PERF_CNT_EN
  , output logic [15:0]         perf_stall_cnt
`endif
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [PC_WIDTH-1:0]   pc;
  logic [DATA_WIDTH-1:0] buf_instr;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next state: flush freezes the FSM so the discarded fetch is simply retried
  always_comb begin
    state_nxt = state;
    if (redirect_valid)  state_nxt = FETCH;
    else if (!flush) begin
      case (state)
        FETCH: if (imem.imem_ready && stall) state_nxt = HOLD;
        HOLD:  if (!stall)                   state_nxt = FETCH;
        default:                             state_nxt = FETCH;
      endcase
    end
  end

  // Outputs: the address is the PC, which only moves on accept or redirect
  always_comb begin
    imem.imem_req  = (state == FETCH);
    imem.imem_addr = pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= PC_WIDTH'(RESET_PC);
      buf_instr <= '0;
      id_valid  <= 1'b0;
      id_pc     <= '0;
      id_instr  <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      buf_instr <= '0;
      id_valid  <= 1'b0;
      id_instr  <= '0;
    end else if (flush) begin
      id_valid  <= 1'b0;
      id_pc     <= '0;
      id_instr  <= '0;
    end else if (stall) begin
      if (state == FETCH && imem.imem_ready) buf_instr <= imem.imem_rdata;
    end else if (state == HOLD) begin
      id_valid  <= 1'b1;
      id_pc     <= pc;
      id_instr  <= buf_instr;
      pc        <= pc + PC_WIDTH'(1);
    end else if (imem.imem_ready) begin
      id_valid  <= 1'b1;
      id_pc     <= pc;
      id_instr  <= imem.imem_rdata;
      pc        <= pc + PC_WIDTH'(1);
    end else begin
      id_valid  <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      perf_stall_cnt <= '0;
    else if ((state == HOLD || (state == FETCH && !imem.imem_ready)) &&
             perf_stall_cnt != 16'hFFFF)
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID contents are queued per step and
// popped after each clock edge.
module tb_if_stage;
  localparam int PW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall, flush, redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          id_valid;
  logic [PW-1:0] id_pc;
  logic [DW-1:0] id_instr;
  logic          garbage;
`ifdef IF_PERF_CNT_EN
  logic [15:0]   perf_stall_cnt;
`endif

  int nerr = 0;
  int nchk = 0;
  logic [31:0] exp_q[$];

  if_stage_if #(.PC_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

  if_stage #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(bus),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr)
`ifdef IF_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] instr_of(input logic [PW-1:0] a);
    return {1'b1, a} ^ 16'h3C3C;
  endfunction

  assign bus.imem_rdata = garbage ? 16'hDEAD : instr_of(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [PW-1:0] p,
                      input logic [DW-1:0] i);
    logic [31:0] e;
    exp_q.push_back({v, p, i});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk({tag, ".valid"}, 32'(id_valid), 32'(e[31]));
    chk({tag, ".pc"},    32'(id_pc),    32'(e[30:16]));
    chk({tag, ".instr"}, 32'(id_instr), 32'(e[15:0]));
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [PW-1:0] addr);
    chk({tag, ".req"},  32'(bus.imem_req),  32'(req));
    chk({tag, ".addr"}, 32'(bus.imem_addr), 32'(addr));
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; bus.imem_ready = 1'b0; garbage = 1'b0;
    #2;
    chk("rst.valid", 32'(id_valid), 32'd0);
    chk("rst.pc",    32'(id_pc),    32'd0);
    chk("rst.instr", 32'(id_instr), 32'd0);
    chk_bus("rst", 1'b1, 15'd0);
`ifdef IF_PERF_CNT_EN
    chk("rst.perf", 32'(perf_stall_cnt), 32'd0);
`endif

    // Streaming fetch after reset release
    @(negedge clk); reset = 1'b1; bus.imem_ready = 1'b1;
    for (int k = 0; k < 5; k++) step("stream", 1'b1, PW'(k), instr_of(PW'(k)));

    // Stall three cycles at PC=5; memory data is corrupted while holding
    stall = 1'b1;
    step("stall0", 1'b1, 15'd4, instr_of(15'd4));
    chk_bus("hold", 1'b0, 15'd5);
    garbage = 1'b1;
    step("stall1", 1'b1, 15'd4, instr_of(15'd4));
    step("stall2", 1'b1, 15'd4, instr_of(15'd4));
    chk_bus("hold2", 1'b0, 15'd5);
    stall = 1'b0;
    step("unhold", 1'b1, 15'd5, instr_of(15'd5));
    garbage = 1'b0;
    chk_bus("unhold", 1'b1, 15'd6);
    step("after", 1'b1, 15'd6, instr_of(15'd6));

    // Redirect while holding a buffered instruction at PC=7
    stall = 1'b1;
    step("hold7", 1'b1, 15'd6, instr_of(15'd6));
    redirect_valid = 1'b1; redirect_pc = 15'h100;
    step("redir", 1'b0, 15'd6, 16'd0);
    chk_bus("redir", 1'b1, 15'h100);
    redirect_valid = 1'b0; stall = 1'b0;
    step("tgt", 1'b1, 15'h100, instr_of(15'h100));

    // Wait states and PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 15'h7FFE;
    step("redir2", 1'b0, 15'h100, 16'd0);
    redirect_valid = 1'b0; bus.imem_ready = 1'b0;
    step("bubble0", 1'b0, 15'h100, 16'd0);
    step("bubble1", 1'b0, 15'h100, 16'd0);
    chk_bus("wait", 1'b1, 15'h7FFE);
    bus.imem_ready = 1'b1;
    step("wrap0", 1'b1, 15'h7FFE, instr_of(15'h7FFE));
    step("wrap1", 1'b1, 15'h7FFF, instr_of(15'h7FFF));
    step("wrap2", 1'b1, 15'h0000, instr_of(15'h0000));
    chk_bus("wrap", 1'b1, 15'd1);

    // Flush with and without stall: IF/ID cleared, PC kept
    stall = 1'b1; flush = 1'b1;
    step("flush_st", 1'b0, 15'd0, 16'd0);
    chk_bus("flush_st", 1'b1, 15'd1);
    stall = 1'b0; flush = 1'b0;
    step("post_fl", 1'b1, 15'd1, instr_of(15'd1));
    flush = 1'b1;
    step("flush", 1'b0, 15'd0, 16'd0);
    chk_bus("flush", 1'b1, 15'd2);
    flush = 1'b0;
    step("post_fl2", 1'b1, 15'd2, instr_of(15'd2));

    // Asynchronous reset in the middle of HOLD
    stall = 1'b1;
    step("hold3", 1'b1, 15'd2, instr_of(15'd2));
    reset = 1'b0; #1;
    chk("arst.valid", 32'(id_valid), 32'd0);
    chk("arst.pc",    32'(id_pc),    32'd0);
    chk("arst.instr", 32'(id_instr), 32'd0);
    chk_bus("arst", 1'b1, 15'd0);
    @(negedge clk); reset = 1'b1; stall = 1'b0;
    step("restart", 1'b1, 15'd0, instr_of(15'd0));

`ifdef IF_PERF_CNT_EN
    reset = 1'b0; #1;
    chk("perf.rst", 32'(perf_stall_cnt), 32'd0);
    @(negedge clk); reset = 1'b1; bus.imem_ready = 1'b0;
    step("pw0", 1'b0, 15'd0, 16'd0);
    step("pw1", 1'b0, 15'd0, 16'd0);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) step("ps", 1'b0, 15'd0, 16'd0);
    chk("perf.cnt", 32'(perf_stall_cnt), 32'd6);
    reset = 1'b0; #1;
    chk("perf.clr", 32'(perf_stall_cnt), 32'd0);
    @(negedge clk); reset = 1'b1; stall = 1'b0;
`endif

    chk("sb.empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
